// File: rtl/pool2_ifm_reader.sv
// Streams D square feature maps out of a dual-port memory as vertical pixel pairs
// (rows 2i and 2i+1) for a 2x2 pooling unit, flagging every completed window.
module pool2_ifm_reader #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned IFM_SIZE         = 14,
  parameter int unsigned IFM_DEPTH        = 3,
  parameter int unsigned KERNAL_SIZE      = 2,
  parameter int unsigned ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
  parameter int unsigned MAP_W            = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [ADDRESS_SIZE_IFM-1:0] mem_addr_A,
  output logic [ADDRESS_SIZE_IFM-1:0] mem_addr_B,
  output logic                        mem_read_enable,
  input  logic [DATA_WIDTH-1:0]       mem_data_in_A,
  input  logic [DATA_WIDTH-1:0]       mem_data_in_B,
  output logic [DATA_WIDTH-1:0]       unit_data_out_A,
  output logic [DATA_WIDTH-1:0]       unit_data_out_B,
  output logic                        fifo_enable,
  output logic                        pool_enable,
  output logic [MAP_W-1:0]            map_index,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned AW       = ADDRESS_SIZE_IFM;
  localparam int unsigned PAIRS    = IFM_SIZE / 2;
  localparam int unsigned COL_W    = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam int unsigned ROW_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int unsigned ROW_STEP = IFM_SIZE + 1;
  // Jump from the last pixel of the last row pair to pixel 0 of the next map;
  // for odd sizes this also skips the unread final row.
  localparam int unsigned MAP_STEP = IFM_SIZE * IFM_SIZE - 2 * PAIRS * IFM_SIZE + IFM_SIZE + 1;

  if (KERNAL_SIZE != 2) begin : g_bad_kernel
    $error("pool2_ifm_reader supports only a 2x2 pooling window");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_drain;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [MAP_W-1:0] r_map;
  logic             r_v1;
  logic             r_odd1;
  logic [MAP_W-1:0] r_map1;

  logic w_last_col;
  logic w_last_row;
  logic w_last_map;

  assign w_last_col = (r_col == COL_W'(IFM_SIZE - 1));
  assign w_last_row = (r_row == ROW_W'(PAIRS - 1));
  assign w_last_map = (r_map == MAP_W'(IFM_DEPTH - 1));

  // Scan sequencer plus the two-stage data/valid pipeline (memory latency + output register).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_drain         <= 1'b0;
      r_col           <= '0;
      r_row           <= '0;
      r_map           <= '0;
      r_v1            <= 1'b0;
      r_odd1          <= 1'b0;
      r_map1          <= '0;
      mem_addr_A      <= '0;
      mem_addr_B      <= '0;
      mem_read_enable <= 1'b0;
      unit_data_out_A <= '0;
      unit_data_out_B <= '0;
      fifo_enable     <= 1'b0;
      pool_enable     <= 1'b0;
      map_index       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      r_v1        <= mem_read_enable;
      r_odd1      <= r_col[0];
      r_map1      <= r_map;
      fifo_enable <= r_v1;
      pool_enable <= r_v1 & r_odd1;
      if (r_v1) begin
        unit_data_out_A <= mem_data_in_A;
        unit_data_out_B <= mem_data_in_B;
        map_index       <= r_map1;
      end
      done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state         <= READ;
            busy            <= 1'b1;
            r_col           <= '0;
            r_row           <= '0;
            r_map           <= '0;
            mem_addr_A      <= '0;
            mem_addr_B      <= AW'(IFM_SIZE);
            mem_read_enable <= 1'b1;
          end
        end

        READ: begin
          if (w_last_col) begin
            r_col <= '0;
            if (w_last_row) begin
              r_row <= '0;
              if (w_last_map) begin
                r_state         <= DRAIN;
                r_drain         <= 1'b0;
                mem_read_enable <= 1'b0;
              end else begin
                r_map      <= r_map + MAP_W'(1);
                mem_addr_A <= mem_addr_A + AW'(MAP_STEP);
                mem_addr_B <= mem_addr_B + AW'(MAP_STEP);
              end
            end else begin
              r_row      <= r_row + ROW_W'(1);
              mem_addr_A <= mem_addr_A + AW'(ROW_STEP);
              mem_addr_B <= mem_addr_B + AW'(ROW_STEP);
            end
          end else begin
            r_col      <= r_col + COL_W'(1);
            mem_addr_A <= mem_addr_A + AW'(1);
            mem_addr_B <= mem_addr_B + AW'(1);
          end
        end

        DRAIN: begin
          if (r_drain) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2_ifm_reader.sv
// Scoreboard bench: a 14x14x3 reader and a 13x13x1 reader, each fed by a memory
// returning (address ^ salt), checked against per-cycle expected event queues.
module tb_pool2_ifm_reader;

  localparam int unsigned AW0 = 10;
  localparam int unsigned AW1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           st0, rs0, st1, rs1;
  logic [AW0-1:0] m0_addr_a, m0_addr_b;
  logic [AW1-1:0] m1_addr_a, m1_addr_b;
  logic           m0_re, m1_re;
  logic [31:0]    m0_din_a, m0_din_b, m1_din_a, m1_din_b;
  logic [31:0]    m0_out_a, m0_out_b, m1_out_a, m1_out_b;
  logic           m0_fe, m0_pe, m1_fe, m1_pe;
  logic [1:0]     m0_map;
  logic [0:0]     m1_map;
  logic           m0_busy, m0_done, m1_busy, m1_done;

  pool2_ifm_reader u_dut0 (
    .clk(clk), .reset(rs0), .start(st0),
    .mem_addr_A(m0_addr_a), .mem_addr_B(m0_addr_b), .mem_read_enable(m0_re),
    .mem_data_in_A(m0_din_a), .mem_data_in_B(m0_din_b),
    .unit_data_out_A(m0_out_a), .unit_data_out_B(m0_out_b),
    .fifo_enable(m0_fe), .pool_enable(m0_pe), .map_index(m0_map),
    .busy(m0_busy), .done(m0_done)
  );

  pool2_ifm_reader #(.IFM_SIZE(13), .IFM_DEPTH(1)) u_dut1 (
    .clk(clk), .reset(rs1), .start(st1),
    .mem_addr_A(m1_addr_a), .mem_addr_B(m1_addr_b), .mem_read_enable(m1_re),
    .mem_data_in_A(m1_din_a), .mem_data_in_B(m1_din_b),
    .unit_data_out_A(m1_out_a), .unit_data_out_B(m1_out_b),
    .fifo_enable(m1_fe), .pool_enable(m1_pe), .map_index(m1_map),
    .busy(m1_busy), .done(m1_done)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned a;
    int unsigned b;
    logic [31:0] da;
    logic [31:0] db;
    bit          pool;
    int unsigned map;
  } ev_t;

  ev_t         qa[2][$];
  ev_t         qo[2][$];
  int unsigned qd[2][$];

  bit          run_active[2];
  int unsigned rk[2], rn[2], zchk[2];
  int unsigned fe_cnt[2], pe_cnt[2];
  logic [31:0] salt[2], last_a[2], last_b[2];
  int unsigned edges = 0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) edges <= edges + 1;

  // Memory models: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    m0_din_a <= m0_re ? (32'(m0_addr_a) ^ salt[0]) : $urandom();
    m0_din_b <= m0_re ? (32'(m0_addr_b) ^ salt[0]) : $urandom();
    m1_din_a <= m1_re ? (32'(m1_addr_a) ^ salt[1]) : $urandom();
    m1_din_b <= m1_re ? (32'(m1_addr_b) ^ salt[1]) : $urandom();
  end

  task automatic chk_eq(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned side(input int u);
    return (u == 1) ? 13 : 14;
  endfunction

  function automatic int unsigned depth(input int u);
    return (u == 1) ? 1 : 3;
  endfunction

  // Reference: a start sampled at edge e on an idle reader yields pair n in cycle e+1+n,
  // its data in cycle e+3+n, and done in cycle e+N+3.
  task automatic model(input int u, input bit st, input bit rs);
    int unsigned e, s, d, n, a;
    ev_t ev;
    e = edges + 1;
    if (rs) begin
      qa[u].delete();
      qo[u].delete();
      qd[u].delete();
      run_active[u] = 1'b0;
      zchk[u]   = e + 1;
      last_a[u] = '0;
      last_b[u] = '0;
    end else if (st && (!run_active[u] || e >= rk[u] + rn[u] + 3)) begin
      s = side(u);
      d = depth(u);
      n = 0;
      for (int unsigned m = 0; m < d; m++)
        for (int unsigned i = 0; i < s / 2; i++)
          for (int unsigned c = 0; c < s; c++) begin
            a       = m * s * s + 2 * i * s + c;
            ev.cyc  = e + 1 + n;
            ev.a    = a;
            ev.b    = a + s;
            ev.da   = a ^ salt[u];
            ev.db   = (a + s) ^ salt[u];
            ev.pool = (c % 2) == 1;
            ev.map  = m;
            qa[u].push_back(ev);
            ev.cyc = e + 3 + n;
            qo[u].push_back(ev);
            n++;
          end
      qd[u].push_back(e + n + 3);
      run_active[u] = 1'b1;
      rk[u] = e;
      rn[u] = n;
      fe_cnt[u] = 0;
      pe_cnt[u] = 0;
    end
  endtask

  task automatic mon(input int u, input int unsigned cyc, input bit re,
                     input int unsigned aa, input int unsigned ab, input bit fe, input bit pe,
                     input int unsigned mi, input logic [31:0] da, input logic [31:0] db,
                     input bit bs, input bit dn);
    ev_t ev;
    bit  exp_busy;
    if (cyc == zchk[u]) begin
      chk_eq("reset_ctrl", {re, fe, pe, bs, dn}, 0);
      chk_eq("reset_addr", {aa, ab}, 0);
      chk_eq("reset_data", {da, db}, 0);
      chk_eq("reset_map", mi, 0);
    end

    while (qa[u].size() > 0 && qa[u][0].cyc < cyc) begin
      chk_eq("addr_missing_cycle", cyc, qa[u][0].cyc);
      void'(qa[u].pop_front());
    end
    if (re) begin
      if (qa[u].size() == 0) chk_eq("addr_unexpected", qa[u].size(), 1);
      else begin
        ev = qa[u].pop_front();
        chk_eq("addr_cycle", cyc, ev.cyc);
        chk_eq("mem_addr_A", aa, ev.a);
        chk_eq("mem_addr_B", ab, ev.b);
      end
      if (u == 1) chk_eq("row12_read", ((aa / 13) == 12) || ((ab / 13) == 12), 0);
    end

    while (qo[u].size() > 0 && qo[u][0].cyc < cyc) begin
      chk_eq("out_missing_cycle", cyc, qo[u][0].cyc);
      void'(qo[u].pop_front());
    end
    if (fe) begin
      if (qo[u].size() == 0) chk_eq("out_unexpected", qo[u].size(), 1);
      else begin
        ev = qo[u].pop_front();
        chk_eq("out_cycle", cyc, ev.cyc);
        chk_eq("unit_data_out_A", da, ev.da);
        chk_eq("unit_data_out_B", db, ev.db);
        chk_eq("pool_enable", pe, ev.pool);
        chk_eq("map_index", mi, ev.map);
        last_a[u] = ev.da;
        last_b[u] = ev.db;
      end
      fe_cnt[u]++;
      if (pe) pe_cnt[u]++;
    end else begin
      chk_eq("hold_A", da, last_a[u]);
      chk_eq("hold_B", db, last_b[u]);
      chk_eq("pool_without_fifo", pe, 0);
    end

    while (qd[u].size() > 0 && qd[u][0] < cyc) begin
      chk_eq("done_missing_cycle", cyc, qd[u][0]);
      void'(qd[u].pop_front());
    end
    if (dn) begin
      if (qd[u].size() == 0) chk_eq("done_unexpected", qd[u].size(), 1);
      else begin
        chk_eq("done_cycle", cyc, qd[u].pop_front());
        chk_eq("done_offset", cyc - rk[u], (u == 1) ? 81 : 297);
        chk_eq("fifo_count", fe_cnt[u], (u == 1) ? 78 : 294);
        chk_eq("pool_count", pe_cnt[u], (u == 1) ? 36 : 147);
      end
    end

    exp_busy = run_active[u] && (cyc >= rk[u] + 1) && (cyc <= rk[u] + rn[u] + 2);
    chk_eq("busy", bs, exp_busy);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, edges + 1, m0_re, 32'(m0_addr_a), 32'(m0_addr_b), m0_fe, m0_pe,
          32'(m0_map), m0_out_a, m0_out_b, m0_busy, m0_done);
      mon(1, edges + 1, m1_re, 32'(m1_addr_a), 32'(m1_addr_b), m1_fe, m1_pe,
          32'(m1_map), m1_out_a, m1_out_b, m1_busy, m1_done);
    end
  end

  // Drives one cycle's inputs just after the monitor has sampled that cycle.
  task automatic step(input bit s0, input bit r0, input bit s1, input bit r1);
    @(negedge clk);
    #1;
    st0 = s0;
    rs0 = r0;
    st1 = s1;
    rs1 = r1;
    model(0, s0, r0);
    model(1, s1, r1);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((qa[0].size() + qo[0].size() + qd[0].size() +
            qa[1].size() + qo[1].size() + qd[1].size()) != 0 && t < budget) begin
      step(0, 0, 0, 0);
      t++;
    end
    chk_eq("idle_timeout", t >= budget, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned tgt;
    int          gap, rst_at;
    st0 = 1'b0; rs0 = 1'b1; st1 = 1'b0; rs1 = 1'b1;
    for (int u = 0; u < 2; u++) begin
      salt[u] = '0; last_a[u] = '0; last_b[u] = '0;
      run_active[u] = 1'b0; zchk[u] = 0; rk[u] = 0; rn[u] = 0;
      fe_cnt[u] = 0; pe_cnt[u] = 0;
    end
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    mon_en = 1'b1;
    step(0, 0, 0, 0);

    // Full runs with data == address on the default reader; a start while busy is ignored.
    salt[0] = '0;
    salt[1] = $urandom();
    step(1, 0, 1, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    wait_idle(2000);

    // Start issued in the done cycle chains a second run on the next edge.
    salt[0] = $urandom();
    step(1, 0, 0, 0);
    tgt = rk[0] + rn[0] + 3;
    while (edges + 2 < tgt) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    wait_idle(2000);

    // Reset sampled at edge k+50 aborts the run, then a fresh start begins at address 0.
    step(1, 0, 0, 0);
    tgt = rk[0] + 50;
    while (edges + 2 < tgt) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    wait_idle(2000);

    // Reset wins over a simultaneous start.
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Randomised runs on the odd-sized reader with stray starts and one mid-run reset.
    for (int r = 0; r < 6; r++) begin
      salt[1] = $urandom();
      gap = int'($urandom_range(0, 4));
      for (int i = 0; i < gap; i++) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      rst_at = int'($urandom_range(5, 70));
      for (int t = 0; t < 90; t++) begin
        if (r == 3 && t == rst_at) step(0, 0, 0, 1);
        else step(0, 0, ($urandom_range(0, 19) == 0) && t < 70, 0);
      end
      wait_idle(1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool2_ifm_reader.md
POOL2_IFM_READER -- requirements
Module: pool2_ifm_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one feature-map pixel word.
REQ-002 SHALL have parameter IFM_SIZE, default 14: input map side length S.
REQ-003 SHALL have parameter IFM_DEPTH, default 3: number of maps D, stored back to back.
REQ-004 SHALL have parameter KERNAL_SIZE, default 2: pooling window side, fixed at 2; any other value is a configuration error.
REQ-005 SHALL have derived parameter ADDRESS_SIZE_IFM, default clog2(S*S*D): memory address width.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1: single-cycle request to stream all D maps.
REQ-009 SHALL have port mem_addr_A, output, ADDRESS_SIZE_IFM: read address for the upper row of the pair.
REQ-010 SHALL have port mem_addr_B, output, ADDRESS_SIZE_IFM: read address for the lower row of the pair.
REQ-011 SHALL have port mem_read_enable, output, 1: both addresses valid.
REQ-012 SHALL have port mem_data_in_A, input, DATA_WIDTH: port-A read data, valid one cycle after its address.
REQ-013 SHALL have port mem_data_in_B, input, DATA_WIDTH: port-B read data, same timing as port A.
REQ-014 SHALL have port unit_data_out_A, output, DATA_WIDTH: upper-row pixel sent to the pooling unit.
REQ-015 SHALL have port unit_data_out_B, output, DATA_WIDTH: lower-row pixel sent to the pooling unit.
REQ-016 SHALL have port fifo_enable, output, 1: unit_data_out_A and unit_data_out_B are valid this cycle.
REQ-017 SHALL have port pool_enable, output, 1: this cycle completes a 2x2 window.
REQ-018 SHALL have port map_index, output, clog2(D), minimum width 1: map currently being emitted on the outputs.
REQ-019 SHALL have port busy, output, 1: operation in progress.
REQ-020 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-021 SHALL implement the FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-022 SHALL move IDLE -> READ on start=1; start in any other state SHALL be ignored.
REQ-023 SHALL, in READ, issue one address pair per cycle with mem_read_enable=1.
REQ-024 SHALL scan the nested counters as d (0..D-1, outermost), row pair i (0..floor(S/2)-1), column c (0..S-1, innermost).
REQ-025 SHALL compute mem_addr_A = d*S*S + 2i*S + c and mem_addr_B = mem_addr_A + S.
REQ-026 SHALL, for odd S, never read the last row; columns are always fully scanned.
REQ-027 SHALL issue N = D*floor(S/2)*S address pairs in total and enter DRAIN after the last pair.
REQ-028 SHALL register unit_data_out_A/B from mem_data_in_A/B, so data appears 2 cycles after its address.
REQ-029 SHALL drive fifo_enable as mem_read_enable delayed 2 cycles.
REQ-030 SHALL assert pool_enable together with fifo_enable only when the emitted column c is odd.
REQ-031 SHALL give map_index the same 2-cycle alignment as the data.
REQ-032 SHALL stay in DRAIN 2 cycles, then return to IDLE with done=1 for exactly one cycle.
REQ-033 SHALL hold busy=1 from the first READ cycle through the last DRAIN cycle.
REQ-034 SHALL give this cycle-level timing, with start sampled at edge k: addresses in cycles k+1..k+N; fifo_enable in cycles k+3..k+N+2; done in cycle k+N+3.
REQ-035 SHALL accept a start arriving in the same cycle as done (IDLE entry) on the following edge.
REQ-036 SHALL hold unit_data_out_A/B at their last value when fifo_enable=0.

Reset
REQ-037 SHALL, when reset=1 at any clock edge, including mid-READ or mid-DRAIN: return to IDLE, clear all counters and pipeline valid bits, and drive every output to 0.
REQ-038 SHALL NOT pulse done for an operation aborted by reset.
REQ-039 SHALL give reset priority over start in the same cycle.

Verification
REQ-040 SHALL check defaults (S=14, D=3), start pulse -> first pair A=0/B=14; last pair A=573/B=587; N=294 pairs.
REQ-041 SHALL check full run -> exactly 294 fifo_enable cycles; exactly 147 pool_enable cycles; done exactly once, at cycle k+297.
REQ-042 SHALL check that a memory model returning data=address -> unit_data_out_A=mem_addr_A and unit_data_out_B=mem_addr_B two cycles after issue, with map_index stepping 0->1->2 at outputs 98 and 196.
REQ-043 SHALL check S=13, D=1 -> N=78 pairs; row 12 never addressed; pool_enable count 36.
REQ-044 SHALL check reset asserted at cycle k+50 -> all outputs 0 the next cycle, no done; a new start then restarts at address 0.
REQ-045 SHALL check start re-asserted while busy -> ignored (counts unchanged); start in the done cycle -> second run begins on the next edge.
